// File: rtl/dff_bank_seq_pkg.sv
// Shared definitions for the CC_DFF bank sequencer.
//   state_t     : sequencer FSM states
//   cfg_t       : per-flop configuration decoded from the instance index
//   STEP_TABLE  : {en, sr} driven during each of the 8 steps
//   MISR_INIT   : signature value loaded at reset and at the start of a run
package dff_bank_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic clk_inv;
        logic en_inv;
        logic sr_inv;
        logic sr_val;
        logic init;
        logic d;
    } cfg_t;

    // Index 0 is the rightmost element: steps 0..7 = 00,10,01,11,10,00,01,11.
    localparam logic [7:0][1:0] STEP_TABLE = {
        2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00
    };

    localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

    // Instance k: configuration index i = k >> 1, D = k[0].
    function automatic cfg_t cfg_of(input logic [5:0] k);
        cfg_t c;
        c.clk_inv = k[1];
        c.en_inv  = k[2];
        c.sr_inv  = k[3];
        c.sr_val  = k[4];
        c.init    = k[5];
        c.d       = k[0];
        return c;
    endfunction

    function automatic logic [1:0] step_vec(input logic [2:0] s);
        return STEP_TABLE[s];
    endfunction

endpackage

// File: rtl/dff_bank_sequencer_if.sv
// Control/status and bank-facing signals of the sequencer.
//   start           : request a run (sequencer samples it only while idle)
//   dut_q           : Q outputs of the flop bank
//   dut_en, dut_sr  : shared EN / SR nets driven into the bank
//   busy, done      : run in progress / one-cycle end-of-run pulse
//   pass, mismatch_cnt, first_fail_step, first_fail_bit, signature : results
//   state_dbg       : current FSM state for observation
//
// Handshake: start is a level request; it is accepted on a rising clock edge
// where the sequencer is idle. busy is high from the cycle after acceptance
// through the last sample step; done pulses for exactly one cycle right after
// that, and the result fields are stable from done until the next acceptance.
interface dff_bank_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
);
    import dff_bank_seq_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dut_q;
    logic             dut_en;
    logic             dut_sr;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [2:0]       first_fail_step;
    logic [5:0]       first_fail_bit;
    logic [31:0]      signature;
    state_t           state_dbg;

    modport master (
        output start, dut_q,
        input  dut_en, dut_sr, busy, done, pass, mismatch_cnt,
               first_fail_step, first_fail_bit, signature, state_dbg
    );

    modport slave (
        input  start, dut_q,
        output dut_en, dut_sr, busy, done, pass, mismatch_cnt,
               first_fail_step, first_fail_bit, signature, state_dbg
    );

endinterface

// File: rtl/dff_bank_golden_model.sv
// Combinational golden model of the flop bank for one step.
//   en, sr     : shared nets as currently driven
//   model      : expected Q of every flop after the previous step
//   known      : flops whose state has been defined since the run started
//   dut_q      : observed Q outputs
//   expected   : expected Q after this step
//   known_next : known mask after this step
//   mism       : bits that are known and disagree with expected
module dff_bank_golden_model
    import dff_bank_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             en,
    input  logic             sr,
    input  logic [WIDTH-1:0] model,
    input  logic [WIDTH-1:0] known,
    input  logic [WIDTH-1:0] dut_q,
    output logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] known_next,
    output logic [WIDTH-1:0] mism
);

    logic [WIDTH-1:0] en_act;
    logic [WIDTH-1:0] sr_act;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        localparam cfg_t C = cfg_of(6'(g));
        assign en_act[g]   = en ^ C.en_inv;
        assign sr_act[g]   = sr ^ C.sr_inv;
        // SR wins over EN; with neither active the flop holds.
        assign expected[g] = sr_act[g] ? C.sr_val : (en_act[g] ? C.d : model[g]);
    end

    assign known_next = known | en_act | sr_act;
    assign mism       = (dut_q ^ expected) & known_next;

endmodule

// File: rtl/dff_bank_sequencer.sv
// Drives the shared EN/SR nets of a CC_DFF bank through an 8-step sequence,
// checks the sampled Q outputs against a golden model and compacts them into
// a MISR signature.
//   clk, rst : system clock (shared with the bank) and synchronous reset
//   bus      : slave side of dff_bank_sequencer_if (start, dut_q in; drive,
//              status and result fields out)
// WIDTH must be even and at most 64; HOLD_CYCLES must be at least 2 so that
// negedge-clocked flops have also captured each vector before sampling.
module dff_bank_sequencer
    import dff_bank_seq_pkg::*;
#(
    parameter int          WIDTH       = 64,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [31:0] MISR_POLY   = 32'h04C1_1DB7,
    parameter int          CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    dff_bank_sequencer_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 2);

    state_t           state;
    logic [2:0]       step;
    logic [7:0]       hold_cnt;
    logic             dut_en_r;
    logic             dut_sr_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       ffs_r;
    logic [5:0]       ffb_r;
    logic [31:0]      sig_r;
    logic [WIDTH-1:0] model_r;
    logic [WIDTH-1:0] known_r;

    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] known_next;
    logic [WIDTH-1:0] mism;

    dff_bank_golden_model #(.WIDTH(WIDTH)) u_golden (
        .en         (dut_en_r),
        .sr         (dut_sr_r),
        .model      (model_r),
        .known      (known_r),
        .dut_q      (bus.dut_q),
        .expected   (expected),
        .known_next (known_next),
        .mism       (mism)
    );

    // Popcount and lowest set bit of this step's mismatches.
    logic [7:0] pop;
    logic [5:0] low_bit;
    always_comb begin
        pop     = '0;
        low_bit = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            pop = pop + 8'(mism[k]);
            if (mism[k]) begin
                low_bit = 6'(k);
            end
        end
    end

    // Saturating accumulate: the wide sum cannot overflow, then clamp.
    logic [CNT_W+7:0] cnt_sum;
    logic [CNT_W-1:0] cnt_next;
    assign cnt_sum  = {8'd0, cnt_r} + {{CNT_W{1'b0}}, pop};
    assign cnt_next = (cnt_sum > {8'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    // MISR folds both 32-bit halves of the bank; missing high bits read as 0.
    logic [63:0] q64;
    logic [31:0] sig_next;
    always_comb begin
        q64             = '0;
        q64[WIDTH-1:0]  = bus.dut_q;
    end
    assign sig_next = {sig_r[30:0], 1'b0} ^ (sig_r[31] ? MISR_POLY : 32'd0)
                    ^ q64[31:0] ^ q64[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            hold_cnt <= '0;
            dut_en_r <= 1'b0;
            dut_sr_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            cnt_r    <= '0;
            ffs_r    <= '0;
            ffb_r    <= '0;
            sig_r    <= MISR_INIT;
            model_r  <= '0;
            known_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state                  <= DRIVE;
                        step                   <= '0;
                        hold_cnt               <= '0;
                        {dut_en_r, dut_sr_r}   <= step_vec(3'd0);
                        busy_r                 <= 1'b1;
                        pass_r                 <= 1'b0;
                        cnt_r                  <= '0;
                        ffs_r                  <= '0;
                        ffb_r                  <= '0;
                        sig_r                  <= MISR_INIT;
                        known_r                <= '0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    cnt_r   <= cnt_next;
                    sig_r   <= sig_next;
                    model_r <= expected;
                    known_r <= known_next;
                    // cnt_r only grows and never wraps, so zero means no
                    // earlier step has failed.
                    if ((cnt_r == '0) && (|mism)) begin
                        ffs_r <= step;
                        ffb_r <= low_bit;
                    end
                    if (step == 3'd7) begin
                        state                <= FINISH;
                        {dut_en_r, dut_sr_r} <= 2'b00;
                        busy_r               <= 1'b0;
                        done_r               <= 1'b1;
                        pass_r               <= (cnt_next == '0);
                    end else begin
                        state                <= DRIVE;
                        step                 <= step + 3'd1;
                        hold_cnt             <= '0;
                        {dut_en_r, dut_sr_r} <= step_vec(step + 3'd1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dut_en          = dut_en_r;
    assign bus.dut_sr          = dut_sr_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.pass            = pass_r;
    assign bus.mismatch_cnt    = cnt_r;
    assign bus.first_fail_step = ffs_r;
    assign bus.first_fail_bit  = ffb_r;
    assign bus.signature       = sig_r;
    assign bus.state_dbg       = state;

endmodule

// File: tb/tb_dff_bank_sequencer.sv
// Bench for dff_bank_sequencer: a behavioural 64-flop CC_DFF bank with
// injectable output faults, a table of directed fault cases, hand-written
// reset and back-to-back sequences, and randomized faults checked against a
// run-level reference model.
module tb_dff_bank_sequencer;

    localparam int          WIDTH      = 64;
    localparam int          HOLD       = 2;
    localparam int          CNT_W      = 8;
    localparam logic [31:0] POLY       = 32'h04C1_1DB7;
    localparam int          DONE_CYCLE = 8 * HOLD + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dff_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    dff_bank_sequencer #(
        .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .MISR_POLY(POLY), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- configuration arithmetic ----------------
    // field: 0 CLK_INV, 1 EN_INV, 2 SR_INV, 3 SR_VAL, 4 INIT
    function automatic bit cfg_bit(input int k, input int field);
        return (((k / 2) >> field) % 2) == 1;
    endfunction

    function automatic logic [WIDTH-1:0] field_mask(input int field);
        logic [WIDTH-1:0] m;
        for (int k = 0; k < WIDTH; k++) m[k] = cfg_bit(k, field);
        return m;
    endfunction

    localparam logic [WIDTH-1:0] CLK_INV_MASK = field_mask(0);

    bit step_en [8] = '{0, 1, 0, 1, 1, 0, 0, 1};
    bit step_sr [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    // ---------------- behavioural flop bank ----------------
    function automatic logic [WIDTH-1:0] bank_next(input logic [WIDTH-1:0] cur,
                                                   input logic en, input logic sr);
        logic [WIDTH-1:0] nxt;
        for (int k = 0; k < WIDTH; k++) begin
            if (sr ^ cfg_bit(k, 2))      nxt[k] = cfg_bit(k, 3);
            else if (en ^ cfg_bit(k, 1)) nxt[k] = (k % 2) == 1;
            else                         nxt[k] = cur[k];
        end
        return nxt;
    endfunction

    logic [WIDTH-1:0] pos_q = field_mask(4);
    logic [WIDTH-1:0] neg_q = field_mask(4);
    always @(posedge clk) pos_q <= bank_next(pos_q, bus.dut_en, bus.dut_sr);
    always @(negedge clk) neg_q <= bank_next(neg_q, bus.dut_en, bus.dut_sr);

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] s0_mask;
    logic [WIDTH-1:0] s1_mask;
    logic [WIDTH-1:0] inv_mask;
    logic [WIDTH-1:0] q_faulty;
    assign bank_q    = (neg_q & CLK_INV_MASK) | (pos_q & ~CLK_INV_MASK);
    assign q_faulty  = ((bank_q ^ inv_mask) & ~s0_mask) | s1_mask;
    assign bus.dut_q = q_faulty;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // ---------------- run-level reference model ----------------
    logic [WIDTH-1:0] q_samp [8];
    int               r_cnt, r_ffs, r_ffb;
    logic             r_pass;
    logic [31:0]      r_sig;

    task automatic ref_model();
        bit   mdl [WIDTH];
        bit   kn  [WIDTH];
        bit   found;
        int   raw;
        raw   = 0;
        found = 0;
        r_ffs = 0;
        r_ffb = 0;
        r_sig = 32'hFFFF_FFFF;
        for (int k = 0; k < WIDTH; k++) begin
            mdl[k] = 0;
            kn[k]  = 0;
        end
        for (int s = 0; s < 8; s++) begin
            logic [63:0] q64;
            for (int k = 0; k < WIDTH; k++) begin
                bit ea, sa, e;
                ea = step_en[s] ^ cfg_bit(k, 1);
                sa = step_sr[s] ^ cfg_bit(k, 2);
                e  = sa ? cfg_bit(k, 3) : (ea ? ((k % 2) == 1) : mdl[k]);
                kn[k] = kn[k] | ea | sa;
                if (kn[k] && (q_samp[s][k] != e)) begin
                    raw++;
                    if (!found) begin
                        found = 1;
                        r_ffs = s;
                        r_ffb = k;
                    end
                end
                mdl[k] = e;
            end
            q64   = 64'(q_samp[s]);
            r_sig = (r_sig << 1) ^ (r_sig[31] ? POLY : 32'd0) ^ q64[31:0] ^ q64[63:32];
        end
        r_cnt  = (raw > 255) ? 255 : raw;
        r_pass = (raw == 0);
    endtask

    // ---------------- driver: one run with a start pulse ----------------
    int          done_at;
    int          done_seen;
    logic        d_pass;
    logic [7:0]  d_cnt;
    logic [2:0]  d_ffs;
    logic [5:0]  d_ffb;
    logic [31:0] d_sig;

    task automatic run_once(input string tag);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_at   = -1;
        done_seen = 0;
        for (int c = 1; c <= DONE_CYCLE + 4; c++) begin
            if (c <= 8 * HOLD) begin
                check({tag, " busy"}, 64'(bus.busy), 64'd1);
                check({tag, " en_sr"}, 64'({bus.dut_en, bus.dut_sr}),
                      64'({step_en[(c-1)/HOLD], step_sr[(c-1)/HOLD]}));
                if (c % HOLD == 0) q_samp[c/HOLD - 1] = q_faulty;
            end
            if (c == DONE_CYCLE) check({tag, " busy_low"}, 64'(bus.busy), 64'd0);
            if (bus.done) begin
                done_seen++;
                if (done_at < 0) begin
                    done_at = c;
                    d_pass  = bus.pass;
                    d_cnt   = bus.mismatch_cnt;
                    d_ffs   = bus.first_fail_step;
                    d_ffb   = bus.first_fail_bit;
                    d_sig   = bus.signature;
                end
            end
            @(posedge clk); #1;
        end
        check({tag, " done_cycle"}, 64'(done_at), 64'(DONE_CYCLE));
        check({tag, " done_pulses"}, 64'(done_seen), 64'd1);
        ref_model();
        check({tag, " cnt_ref"},  64'(d_cnt),  64'(r_cnt));
        check({tag, " ffs_ref"},  64'(d_ffs),  64'(r_ffs));
        check({tag, " ffb_ref"},  64'(d_ffb),  64'(r_ffb));
        check({tag, " pass_ref"}, 64'(d_pass), 64'(r_pass));
        check({tag, " sig_ref"},  64'(d_sig),  64'(r_sig));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] s0;
        logic [WIDTH-1:0] s1;
        logic [WIDTH-1:0] inv;
        logic             exp_pass;
        int               exp_cnt;
        int               exp_ffs;
        int               exp_ffb;
    } vec_t;

    localparam int NV = 6;
    vec_t        vecs [NV];
    logic [31:0] vec_sig [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int dn_cyc  [2];
        logic dn_pass [2];
        logic [7:0] dn_cnt [2];

        // clean, bit5 stuck0, bit0 stuck1, all inverted, clean x2
        vecs[0] = '{64'd0, 64'd0, 64'd0, 1'b1, 0, 0, 0};
        vecs[1] = '{64'h20, 64'd0, 64'd0, 1'b0, 3, 0, 5};
        vecs[2] = '{64'd0, 64'h1, 64'd0, 1'b0, 7, 1, 0};
        vecs[3] = '{64'd0, 64'd0, {64{1'b1}}, 1'b0, 255, 0, 4};
        vecs[4] = '{64'd0, 64'd0, 64'd0, 1'b1, 0, 0, 0};
        vecs[5] = '{64'd0, 64'd0, 64'd0, 1'b1, 0, 0, 0};

        bus.start = 1'b0;
        s0_mask   = '0;
        s1_mask   = '0;
        inv_mask  = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy",  64'(bus.busy), 64'd0);
        check("rst done",  64'(bus.done), 64'd0);
        check("rst pass",  64'(bus.pass), 64'd0);
        check("rst en_sr", 64'({bus.dut_en, bus.dut_sr}), 64'd0);
        check("rst cnt",   64'(bus.mismatch_cnt), 64'd0);
        check("rst ffs",   64'(bus.first_fail_step), 64'd0);
        check("rst ffb",   64'(bus.first_fail_bit), 64'd0);
        check("rst sig",   64'(bus.signature), 64'hFFFF_FFFF);
        check("rst state", 64'(bus.state_dbg), 64'(dff_bank_seq_pkg::IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            s0_mask  = vecs[v].s0;
            s1_mask  = vecs[v].s1;
            inv_mask = vecs[v].inv;
            run_once($sformatf("vec%0d", v));
            check($sformatf("vec%0d pass", v), 64'(d_pass), 64'(vecs[v].exp_pass));
            check($sformatf("vec%0d cnt", v),  64'(d_cnt),  64'(vecs[v].exp_cnt));
            check($sformatf("vec%0d ffs", v),  64'(d_ffs),  64'(vecs[v].exp_ffs));
            check($sformatf("vec%0d ffb", v),  64'(d_ffb),  64'(vecs[v].exp_ffb));
            vec_sig[v] = d_sig;
        end
        check("repeat sig", 64'(vec_sig[5]), 64'(vec_sig[4]));
        s0_mask  = '0;
        s1_mask  = '0;
        inv_mask = '0;

        // reset in the middle of a run
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy",  64'(bus.busy), 64'd0);
        check("midrst en_sr", 64'({bus.dut_en, bus.dut_sr}), 64'd0);
        check("midrst sig",   64'(bus.signature), 64'hFFFF_FFFF);
        check("midrst done",  64'(bus.done), 64'd0);
        rst    = 1'b0;
        n_done = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("midrst no_done", 64'(n_done), 64'd0);
        run_once("after_rst");
        check("after_rst pass", 64'(d_pass), 64'd1);

        // start held high: two back-to-back runs, fault only in the first
        s1_mask   = 64'h1;
        n_done    = 0;
        bus.start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (c == 30) bus.start = 1'b0;
            if (bus.done) begin
                if (n_done < 2) begin
                    dn_cyc[n_done]  = c;
                    dn_pass[n_done] = bus.pass;
                    dn_cnt[n_done]  = bus.mismatch_cnt;
                end
                n_done++;
                s1_mask = '0;
            end
        end
        check("b2b done_count", 64'(n_done), 64'd2);
        if (n_done >= 2) begin
            check("b2b done1_cycle", 64'(dn_cyc[0]), 64'(DONE_CYCLE));
            check("b2b done2_cycle", 64'(dn_cyc[1]), 64'(2 * DONE_CYCLE + 1));
            check("b2b pass1", 64'(dn_pass[0]), 64'd0);
            check("b2b cnt1",  64'(dn_cnt[0]),  64'd7);
            check("b2b pass2", 64'(dn_pass[1]), 64'd1);
            check("b2b cnt2",  64'(dn_cnt[1]),  64'd0);
        end

        // randomized faults against the reference model
        for (int r = 0; r < 10; r++) begin
            s0_mask  = '0;
            s1_mask  = '0;
            inv_mask = '0;
            repeat ($urandom_range(0, 3)) s0_mask[$urandom_range(0, WIDTH - 1)] = 1'b1;
            repeat ($urandom_range(0, 3)) s1_mask[$urandom_range(0, WIDTH - 1)] = 1'b1;
            repeat ($urandom_range(0, 2)) inv_mask[$urandom_range(0, WIDTH - 1)] = 1'b1;
            if (r == 9) inv_mask = {$urandom, $urandom};
            run_once($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
